// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset sequencer.
// Build option: MC_ILLEGAL_TRAP_EN adds the HALT trap state for unknown opcodes.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        ST_HALT   = 3'd5
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b010001;
    localparam logic [5:0] OP_SW    = 6'b010000;
    localparam logic [5:0] OP_SUBIU = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b101010;

    localparam logic [1:0] ALUOP_ADDU  = 2'b00;
    localparam logic [1:0] ALUOP_SUBU  = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLTI  = 2'b11;

    // Datapath control bundle produced by the output decoder
    typedef struct packed {
        logic       pc_w;
        logic       ir_w;
        logic       i_r;
        logic       reg_dst;
        logic       reg_w;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       mem_r;
        logic       mem_w;
        logic       mem_to_reg;
        logic       done;
        logic       illegal;
    } ctl_t;

    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_SUBIU) || (op == OP_SLTI);
    endfunction

    function automatic logic op_is_mem(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // ALU setting an instruction class uses in EXEC and WB
    function automatic logic [1:0] alu_op_for(input logic [5:0] op);
        logic [1:0] r;
        case (op)
            OP_RTYPE: r = ALUOP_RTYPE;
            OP_SUBIU: r = ALUOP_SUBU;
            OP_SLTI:  r = ALUOP_SLTI;
            default:  r = ALUOP_ADDU;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational map from (state, latched opcode, ready strobes) to datapath controls.
// Build option: MC_ILLEGAL_TRAP_EN enables the Illegal flag in HALT.
module mc_out_decode
    import mc_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] op_i,
    input  logic       i_ready_i,
    input  logic       d_ready_i,
    output ctl_t       ctl_o
);

    // Per-state control decode; everything not named for a state stays 0
    always_comb begin
        ctl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctl_o.i_r  = 1'b1;
                ctl_o.pc_w = i_ready_i;
                ctl_o.ir_w = i_ready_i;
            end
            ST_DECODE: begin
                ctl_o = '0;
            end
            ST_EXEC: begin
                ctl_o.alu_op  = alu_op_for(op_i);
                ctl_o.alu_src = (op_i != OP_RTYPE);
            end
            ST_MEM: begin
                ctl_o.alu_op  = ALUOP_ADDU;
                ctl_o.alu_src = 1'b1;
                ctl_o.mem_r   = (op_i == OP_LW);
                ctl_o.mem_w   = (op_i == OP_SW);
                // A store retires in the cycle its data access completes
                ctl_o.done    = (op_i == OP_SW) && d_ready_i;
            end
            ST_WB: begin
                ctl_o.reg_w      = 1'b1;
                ctl_o.done       = 1'b1;
                ctl_o.alu_op     = alu_op_for(op_i);
                ctl_o.alu_src    = (op_i != OP_RTYPE);
                ctl_o.reg_dst    = (op_i == OP_RTYPE);
                ctl_o.mem_to_reg = (op_i == OP_LW);
            end
`ifdef MC_ILLEGAL_TRAP_EN
            ST_HALT: begin
                ctl_o.illegal = 1'b1;
            end
`endif
            default: begin
                ctl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-ready handshakes,
// opcode latch and retired-instruction counter.
// Build option: MC_ILLEGAL_TRAP_EN traps unknown opcodes in HALT; otherwise they are NOPs.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Opcode,
    input  logic             I_ready,
    input  logic             D_ready,
    output logic             PC_w,
    output logic             IR_w,
    output logic             I_r,
    output logic             Reg_dst,
    output logic             Reg_w,
    output logic [1:0]       ALU_op,
    output logic             ALU_src,
    output logic             Mem_r,
    output logic             Mem_w,
    output logic             Mem_to_reg,
    output logic             Done,
    output logic [CNT_W-1:0] Instr_cnt,
    output logic             Illegal
);

    state_t           state_q, state_d;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctl_t             ctl;

    // State register with synchronous reset priority over every transition
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    // Opcode latch (DECODE only) and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (state_q == ST_DECODE) op_q <= Opcode;
            cnt_q <= cnt_d;
        end
    end

    // Next-state logic; DECODE branches on the live opcode because op_q updates on the same edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (I_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (op_known(Opcode)) state_d = ST_EXEC;
`ifdef MC_ILLEGAL_TRAP_EN
                else                  state_d = ST_HALT;
`else
                else                  state_d = ST_FETCH;
`endif
            end
            ST_EXEC:   state_d = op_is_mem(op_q) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (D_ready) state_d = (op_q == OP_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB:     state_d = ST_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            ST_HALT:   state_d = ST_HALT;
`endif
            default:   state_d = ST_FETCH;
        endcase
    end

    mc_out_decode u_out_decode (
        .state_i   (state_q),
        .op_i      (op_q),
        .i_ready_i (I_ready),
        .d_ready_i (D_ready),
        .ctl_o     (ctl)
    );

    // Output drive and counter advance on each retirement (wraps naturally)
    always_comb begin
        PC_w       = ctl.pc_w;
        IR_w       = ctl.ir_w;
        I_r        = ctl.i_r;
        Reg_dst    = ctl.reg_dst;
        Reg_w      = ctl.reg_w;
        ALU_op     = ctl.alu_op;
        ALU_src    = ctl.alu_src;
        Mem_r      = ctl.mem_r;
        Mem_w      = ctl.mem_w;
        Mem_to_reg = ctl.mem_to_reg;
        Done       = ctl.done;
        Illegal    = ctl.illegal;
        Instr_cnt  = cnt_q;
        cnt_d      = cnt_q + CNT_W'(ctl.done);
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus builds each instruction's
// expected per-cycle control trace from the instruction-class rules; a monitor
// compares every cycle against the queued expectation.
module tb_multicycle_control;

    localparam int unsigned CW = 4;

    localparam logic [5:0] T_RT    = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b010001;
    localparam logic [5:0] T_SW    = 6'b010000;
    localparam logic [5:0] T_SUBIU = 6'b001101;
    localparam logic [5:0] T_SLTI  = 6'b101010;

    localparam int B_DONE = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    Opcode;
    logic          I_ready, D_ready;
    logic          PC_w, IR_w, I_r, Reg_dst, Reg_w, ALU_src, Mem_r, Mem_w, Mem_to_reg, Done, Illegal;
    logic [1:0]    ALU_op;
    logic [CW-1:0] Instr_cnt;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .Opcode     (Opcode),
        .I_ready    (I_ready),
        .D_ready    (D_ready),
        .PC_w       (PC_w),
        .IR_w       (IR_w),
        .I_r        (I_r),
        .Reg_dst    (Reg_dst),
        .Reg_w      (Reg_w),
        .ALU_op     (ALU_op),
        .ALU_src    (ALU_src),
        .Mem_r      (Mem_r),
        .Mem_w      (Mem_w),
        .Mem_to_reg (Mem_to_reg),
        .Done       (Done),
        .Instr_cnt  (Instr_cnt),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    logic [12:0]   ctl_q[$];
    logic [CW-1:0] cnt_exp_q[$];
    string         tag_q[$];
    logic [CW-1:0] model_cnt;
    int            checks = 0;
    int            errors = 0;

    wire [12:0] act_ctl = {PC_w, IR_w, I_r, Reg_dst, Reg_w, ALU_op, ALU_src,
                           Mem_r, Mem_w, Mem_to_reg, Done, Illegal};

    // Monitor: one expected cycle per falling edge
    always @(negedge clk) begin
        logic [12:0]   ec;
        logic [CW-1:0] en;
        string         tg;
        if (ctl_q.size() != 0) begin
            ec = ctl_q.pop_front();
            en = cnt_exp_q.pop_front();
            tg = tag_q.pop_front();
            checks = checks + 1;
            if (act_ctl !== ec || Instr_cnt !== en) begin
                errors = errors + 1;
                $display("FAIL %s: ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                         tg, act_ctl, Instr_cnt, ec, en);
            end
        end
    end

    function automatic logic [12:0] c(input logic pcw, input logic irw, input logic ir,
                                      input logic rdst, input logic rw, input logic [1:0] alu,
                                      input logic src, input logic mr, input logic mw,
                                      input logic m2r, input logic dn, input logic ill);
        return {pcw, irw, ir, rdst, rw, alu, src, mr, mw, m2r, dn, ill};
    endfunction

    function automatic logic known(input logic [5:0] op);
        return (op == T_RT) || (op == T_LW) || (op == T_SW) || (op == T_SUBIU) || (op == T_SLTI);
    endfunction

    function automatic logic [1:0] alu_of(input logic [5:0] op);
        if (op == T_RT)    return 2'b10;
        if (op == T_SUBIU) return 2'b01;
        if (op == T_SLTI)  return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be during it
    task automatic step(input logic ir, input logic dr, input logic [5:0] op,
                        input logic r, input logic [12:0] ctl, input string tag);
        I_ready = ir;
        D_ready = dr;
        Opcode  = op;
        rst     = r;
        ctl_q.push_back(ctl);
        cnt_exp_q.push_back(model_cnt);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (r)                model_cnt = '0;
        else if (ctl[B_DONE]) model_cnt = model_cnt + 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int unsigned iw,
                             input int unsigned dw, input logic rst_mem);
        logic [1:0] a;
        logic       s, lw, sw;
        string      t;
        t = $sformatf("op%02h", op);
        for (int unsigned i = 0; i < iw; i++)
            step(1'b0, rb(), rop(), 1'b0, c(0,0,1,0,0,2'b00,0,0,0,0,0,0), {t, "_fetchwait"});
        step(1'b1, rb(), rop(), 1'b0, c(1,1,1,0,0,2'b00,0,0,0,0,0,0), {t, "_fetch"});
        step(rb(), rb(), op, 1'b0, '0, {t, "_decode"});
        if (!known(op)) begin
`ifdef MC_ILLEGAL_TRAP_EN
            for (int unsigned i = 0; i < 3; i++)
                step(rb(), rb(), rop(), 1'b0, c(0,0,0,0,0,2'b00,0,0,0,0,0,1), {t, "_halt"});
            step(rb(), rb(), rop(), 1'b1, c(0,0,0,0,0,2'b00,0,0,0,0,0,1), {t, "_halt_rst"});
`endif
            return;
        end
        a  = alu_of(op);
        s  = (op != T_RT);
        lw = (op == T_LW);
        sw = (op == T_SW);
        step(rb(), rb(), rop(), 1'b0, c(0,0,0,0,0,a,s,0,0,0,0,0), {t, "_exec"});
        if (lw || sw) begin
            for (int unsigned i = 0; i < dw; i++)
                step(rb(), 1'b0, rop(), 1'b0, c(0,0,0,0,0,2'b00,1,lw,sw,0,0,0), {t, "_memwait"});
            if (rst_mem) begin
                step(rb(), 1'b0, rop(), 1'b1, c(0,0,0,0,0,2'b00,1,lw,sw,0,0,0), {t, "_mem_rst"});
                return;
            end
            step(rb(), 1'b1, rop(), 1'b0, c(0,0,0,0,0,2'b00,1,lw,sw,0,sw,0), {t, "_mem"});
            if (sw) return;
        end
        step(rb(), rb(), rop(), 1'b0, c(0,0,0,(op == T_RT),1,a,s,0,0,lw,1,0), {t, "_wb"});
    endtask

    initial begin
        logic [5:0]  legal [5];
        logic [5:0]  op;
        int unsigned pick;
        legal[0] = T_RT; legal[1] = T_LW; legal[2] = T_SW; legal[3] = T_SUBIU; legal[4] = T_SLTI;
        model_cnt = '0;
        rst = 1'b1; I_ready = 1'b0; D_ready = 1'b0; Opcode = '0;
        repeat (2) @(posedge clk);
        #1;

        // Directed scenarios
        run_instr(T_RT,    0, 0, 1'b0);
        run_instr(T_LW,    0, 3, 1'b0);
        run_instr(T_SW,    0, 0, 1'b0);
        run_instr(T_SUBIU, 0, 0, 1'b0);
        run_instr(T_SLTI,  0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(T_SW,    1, 1, 1'b1);
        for (int unsigned i = 0; i < 18; i++) run_instr(T_RT, 0, 0, 1'b0);

        // Randomized instruction stream
        for (int unsigned n = 0; n < 160; n++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0) op = rop();
            else           op = legal[$urandom_range(0, 4)];
            run_instr(op, ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3),
                      $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (ctl_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: pending=%0d expected 0", ctl_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
